// File: rtl/mc_alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU and its multiplier.
package mc_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_t;

    localparam int MUL_STEPS = 8;

endpackage

// File: rtl/mc_alu_mul.sv
// Shift-add 8x8 unsigned multiplier: one multiplier bit consumed per step.
module mc_alu_mul
    import mc_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        last
);

    logic [15:0] acc_reg;
    logic [15:0] mcand_reg;
    logic [7:0]  mplier_reg;
    logic [2:0]  cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {8'h00, a};
            mplier_reg <= b;
            cnt_reg    <= '0;
        end else if (step) begin
            if (mplier_reg[0])
                acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= {mcand_reg[14:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[7:1]};
            cnt_reg    <= cnt_reg + 3'd1;
        end
    end

    assign product = acc_reg;
    assign last    = (cnt_reg == 3'(MUL_STEPS - 1));

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle 8-bit ALU writing results back into a register file; MUL writes
// the low byte to dst and the high byte to dst+1.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int pw = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [pw:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        wr_en,
    output logic [pw:0] wr_addr,
    output logic [7:0]  wr_dat,
    output logic        carry,
    output logic        zero
);

    state_t      state_reg, state_next;
    op_t         op_reg;
    logic [pw:0] dst_reg;
    logic [7:0]  res_reg;
    logic        carry_reg, zero_reg;

    logic        accept;
    logic        mul_step;
    logic        mul_last;
    logic [15:0] product;
    logic [8:0]  alu_res;

    assign accept = (state_reg == S_IDLE) && start;

    mc_alu_mul u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (mul_step),
        .a       (a_in),
        .b       (b_in),
        .product (product),
        .last    (mul_last)
    );

    // Bit 8 carries the carry/borrow flag of the single-cycle ops.
    always_comb begin
        alu_res = '0;
        case (op_t'(op))
            OP_ADD:  alu_res = {1'b0, a_in} + {1'b0, b_in};
            OP_SUB:  alu_res = {1'b0, a_in} - {1'b0, b_in};
            OP_AND:  alu_res = {1'b0, a_in & b_in};
            OP_XOR:  alu_res = {1'b0, a_in ^ b_in};
            OP_SHL:  alu_res = {a_in[7], a_in[6:0], 1'b0};
            OP_SHR:  alu_res = {a_in[0], 1'b0, a_in[7:1]};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_ADD;
            dst_reg   <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Single-cycle flags are registered on accept so they are visible in the done cycle.
            if (accept) begin
                op_reg  <= op_t'(op);
                dst_reg <= dst_addr;
                res_reg <= alu_res[7:0];
                if (op_t'(op) != OP_MUL && op_t'(op) != OP_NOP) begin
                    carry_reg <= alu_res[8];
                    zero_reg  <= (alu_res[7:0] == 8'h00);
                end
            end
            if (state_reg == S_WB_LO && op_reg == OP_MUL) begin
                carry_reg <= |product[15:8];
                zero_reg  <= (product == 16'h0000);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mul_step   = 1'b0;
        done       = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_dat     = '0;
        case (state_reg)
            S_IDLE: begin
                if (start)
                    state_next = (op_t'(op) == OP_MUL) ? S_MUL : S_WB_LO;
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_last)
                    state_next = S_WB_LO;
            end
            S_WB_LO: begin
                state_next = (op_reg == OP_MUL) ? S_WB_HI : S_IDLE;
                done       = (op_reg != OP_MUL);
                if (op_reg != OP_NOP) begin
                    wr_en   = 1'b1;
                    wr_addr = dst_reg;
                    wr_dat  = (op_reg == OP_MUL) ? product[7:0] : res_reg;
                end
            end
            S_WB_HI: begin
                state_next = S_IDLE;
                done       = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = dst_reg + (pw+1)'(1);
                wr_dat     = product[15:8];
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy  = (state_reg != S_IDLE);
    assign carry = carry_reg;
    assign zero  = zero_reg;

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: directed scenarios plus randomized operations
// checked cycle by cycle against an arithmetic reference model.
module tb_mc_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a_in, b_in;
    logic [2:0] dst_addr;
    logic       busy, done, wr_en, carry, zero;
    logic [2:0] wr_addr;
    logic [7:0] wr_dat;

    int  tests = 0;
    int  fails = 0;
    bit  m_carry = 0;
    bit  m_zero = 0;
    logic [7:0] last_dat;
    logic [2:0] last_addr;

    mc_alu #(.pw(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_dat   (wr_dat),
        .carry    (carry),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_dat"}, 32'(wr_dat), 0);
        check({tag, "_carry"}, 32'(carry), 0);
        check({tag, "_zero"}, 32'(zero), 0);
    endtask

    // Issues one operation, then checks every cycle until its done cycle.
    // junk=1 keeps hammering start with random inputs while the ALU is busy.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] d, input bit junk);
        int ai, bi, full, r, lat;
        bit c, exp_we;
        logic [2:0] d1;
        logic [2:0] exp_addr;
        logic [7:0] exp_dat;
        ai = a; bi = b; full = 0; r = 0; c = 0;
        d1 = d + 3'd1;
        case (o)
            3'd0: begin full = ai + bi; r = full % 256; c = (full > 255); end
            3'd1: begin r = (ai - bi + 256) % 256; c = (ai < bi); end
            3'd2: begin r = ai & bi; c = 0; end
            3'd3: begin r = ai ^ bi; c = 0; end
            3'd4: begin r = (ai * 2) % 256; c = (ai >= 128); end
            3'd5: begin r = ai / 2; c = ai % 2; end
            3'd6: begin full = ai * bi; c = (full > 255); end
            default: ;
        endcase
        lat = (o == 3'd6) ? 10 : 1;

        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b; dst_addr = d;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (junk) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
                a_in = 8'($urandom); b_in = 8'($urandom);
                dst_addr = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            exp_we = (o == 3'd6) ? (k >= 9) : (o != 3'd7);
            check($sformatf("op%0d_c%0d_busy", o, k), 32'(busy), 1);
            check($sformatf("op%0d_c%0d_done", o, k), 32'(done), 32'(k == lat));
            check($sformatf("op%0d_c%0d_wr_en", o, k), 32'(wr_en), 32'(exp_we));
            if (exp_we) begin
                if (o == 3'd6) begin
                    exp_addr = (k == 10) ? d1 : d;
                    exp_dat  = (k == 10) ? 8'(full / 256) : 8'(full % 256);
                end else begin
                    exp_addr = d;
                    exp_dat  = 8'(r);
                end
                check($sformatf("op%0d_c%0d_wr_addr", o, k), 32'(wr_addr), 32'(exp_addr));
                check($sformatf("op%0d_c%0d_wr_dat", o, k), 32'(wr_dat), 32'(exp_dat));
                last_dat  = wr_dat;
                last_addr = wr_addr;
            end
            if (k == lat) begin
                if (o != 3'd7) begin
                    m_carry = c;
                    m_zero  = (o == 3'd6) ? (full == 0) : (r == 0);
                end
                check($sformatf("op%0d_carry", o), 32'(carry), 32'(m_carry));
                check($sformatf("op%0d_zero", o), 32'(zero), 32'(m_zero));
            end
        end
        @(negedge clk);
        start = 1'b0;
        check($sformatf("op%0d_after_busy", o), 32'(busy), 0);
        check($sformatf("op%0d_after_wr_en", o), 32'(wr_en), 0);
        check($sformatf("op%0d_after_done", o), 32'(done), 0);
        $display("[TB] op=%0d a=%02h b=%02h dst=%0d junk=%0d -> carry=%0d zero=%0d",
                 o, a, b, d, junk, carry, zero);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; dst_addr = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset_hold");
        reset = 1'b0;
        @(negedge clk);
        check_quiet("reset_after");

        // ADD F0+20 -> 10 with carry
        run_op(3'd0, 8'hF0, 8'h20, 3'd1, 1'b0);
        check("add_dat", 32'(last_dat), 32'h10);
        check("add_carry", 32'(carry), 1);
        check("add_zero", 32'(zero), 0);

        // MUL FF*FF = FE01
        run_op(3'd6, 8'hFF, 8'hFF, 3'd2, 1'b0);
        check("mulff_hi", 32'(last_dat), 32'hFE);
        check("mulff_addr", 32'(last_addr), 3);
        check("mulff_carry", 32'(carry), 1);

        // MUL 3*4, high byte wraps to address 0
        run_op(3'd6, 8'h03, 8'h04, 3'd7, 1'b0);
        check("mul34_hi", 32'(last_dat), 0);
        check("mul34_addr", 32'(last_addr), 0);
        check("mul34_carry", 32'(carry), 0);
        check("mul34_zero", 32'(zero), 0);

        // SUB 5-5 with start held during busy
        run_op(3'd1, 8'h05, 8'h05, 3'd4, 1'b1);
        check("sub_dat", 32'(last_dat), 0);
        check("sub_zero", 32'(zero), 1);
        check("sub_carry", 32'(carry), 0);

        // NOP keeps carry set by the preceding ADD
        run_op(3'd0, 8'hFF, 8'h01, 3'd6, 1'b0);
        run_op(3'd7, 8'h12, 8'h34, 3'd5, 1'b0);
        check("nop_carry", 32'(carry), 1);

        // Reset in the 4th MUL cycle aborts the multiply
        @(negedge clk);
        start = 1'b1; op = 3'd6; a_in = 8'hA5; b_in = 8'h5A; dst_addr = 3'd3;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("abort_in_reset");
        reset = 1'b0;
        m_carry = 0; m_zero = 0;
        @(negedge clk);
        check_quiet("abort_after");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_write", 32'(wr_en), 0);
        end
        run_op(3'd0, 8'h01, 8'h01, 3'd5, 1'b0);
        check("post_abort_add", 32'(last_dat), 2);

        for (int i = 0; i < 60; i++)
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   3'($urandom), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter pw, default 2, register address pointer width minus one; register addresses are pw+1 bits wide.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-005 op  input  3  operation code; captured on acceptance.
REQ-006 a_in  input  8  operand A, fed from register file read port A; captured on acceptance.
REQ-007 b_in  input  8  operand B, fed from register file read port B; captured on acceptance.
REQ-008 dst_addr  input  pw+1  destination register address; captured on acceptance.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  one-cycle pulse marking the final cycle of an operation.
REQ-011 wr_en  output  1  register file write enable.
REQ-012 wr_addr  output  pw+1  register file write address.
REQ-013 wr_dat  output  8  register file write data.
REQ-014 carry  output  1  carry/borrow flag register.
REQ-015 zero  output  1  zero flag register.

Function
REQ-016 Opcodes SHALL be: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 XOR; 100 SHL a<<1; 101 SHR a>>1 (logical); 110 MUL, 16-bit unsigned a*b; 111 NOP.
REQ-017 FSM states SHALL be IDLE, MUL, WB_LO, WB_HI, with busy = (state != IDLE).
REQ-018 start=1 in IDLE SHALL be accepted: operands, op and dst_addr are registered; the next state is MUL for op 110 and WB_LO otherwise.
REQ-019 start while busy=1, including the done cycle, SHALL be ignored, with no capture and no effect on the current operation.
REQ-020 Single-cycle ops SHALL spend exactly one cycle in WB_LO (wr_en=1, wr_addr=dst, wr_dat=result, done=1), then return to IDLE; latency from the accept edge is 1 cycle.
REQ-021 NOP SHALL pass through WB_LO with done=1, wr_en=0, flags unchanged.
REQ-022 MUL SHALL use shift-add, one multiplier bit per cycle: exactly 8 cycles in MUL (3-bit counter 0..7), then WB_LO (low byte to dst), then WB_HI (high byte to dst+1 modulo 2**(pw+1), done=1), then IDLE; total latency is 10 cycles.
REQ-023 done SHALL be asserted only in the final write cycle (WB_LO for non-MUL ops, WB_HI for MUL), and wr_en SHALL NOT assert in IDLE or MUL.
REQ-024 carry SHALL update in the done cycle as follows: ADD carry-out bit 8; SUB borrow (1 when a<b); SHL a[7]; SHR a[0]; logic ops clear it; MUL sets it when the high byte is nonzero.
REQ-025 zero SHALL update in the done cycle to 1 when the full result (16-bit for MUL) is 0; NOP leaves it unchanged.
REQ-026 wr_en, wr_addr, wr_dat and done SHALL derive only from registered state, with no combinational path from the inputs.
REQ-027 8-bit results SHALL wrap modulo 256, with only the flags reporting overflow.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, clear the counter, operand and result registers, and clear carry and zero.
REQ-029 While in reset and in the cycle after, busy, done, wr_en, wr_addr and wr_dat SHALL all be 0.
REQ-030 Reset mid-operation, including during MUL or WB_LO of a MUL, SHALL abort the operation with no further register writes.
REQ-031 reset SHALL take priority over start in the same cycle.

Structure
REQ-032 A package mc_alu_pkg SHALL hold the opcode enum (3-bit) and the FSM state enum.
REQ-033 The shift-add datapath SHALL be one sub-module, mc_alu_mul, holding the accumulator, multiplicand and counter, controlled by load/step inputs from the mc_alu FSM.

Verification
REQ-034 ADD a=F0 b=20 dst=1, start for one cycle -> next cycle wr_en=1 addr=1 dat=10 done=1 carry=1 zero=0; busy low the following cycle.
REQ-035 MUL a=FF b=FF dst=2 -> busy for 10 cycles, wr 01 to addr 2 at cycle 9, wr FE to addr 3 at cycle 10 with done, carry=1.
REQ-036 MUL a=03 b=04 dst=7 (pw=2) -> wr 0C to addr 7, then 00 to addr 0, zero=0, carry=0.
REQ-037 SUB a=05 b=05 with a second start pulse issued during busy -> single write of 00, zero=1, carry=0; the second start is ignored.
REQ-038 MUL started, reset asserted at the 4th MUL cycle -> no wr_en afterwards, busy=0 and flags 0 the next cycle; then ADD 01+01 completes normally, writing 02.
REQ-039 NOP after an ADD that set carry=1 -> done pulse with wr_en=0, and carry stays 1.
